fetch: RTL and testbench

Instruction fetch pipeline stage, directly upstream of decode. It owns the program counter and issues single-outstanding read requests on the instruction bus. It delivers each instruction word with its PC to decode, and asserts o_fetch_stall whenever no valid word is available. It also handles control-flow redirects coming back from execute, and holds a returned word while the core is stalled.

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/fetch_hold_buf.sv | 32 +++
 rtl/fetch.sv | 169 ++++++++++++++++
 tb/tb_fetch.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants, state encoding and word record for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned CPU_ADDR_WIDTH  = 32;
    localparam int unsigned CPU_INSTR_WIDTH = 32;

    localparam logic [CPU_INSTR_WIDTH-1:0] NOP_WORD_DEFAULT     = 32'h0000_0000;
    localparam logic [CPU_ADDR_WIDTH-1:0]  RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
    localparam logic [CPU_ADDR_WIDTH-1:0]  PC_STEP              = 32'd4;

    typedef enum logic [1:0] {
        StBoot,
        StReq,
        StHold
    } fetch_state_e;

    typedef struct packed {
        logic [CPU_ADDR_WIDTH-1:0]  pc;
        logic [CPU_INSTR_WIDTH-1:0] instr;
        logic                       err;
    } fetch_word_t;

    function automatic logic [CPU_ADDR_WIDTH-1:0] word_align(
        input logic [CPU_ADDR_WIDTH-1:0] addr
    );
        return {addr[CPU_ADDR_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry buffer keeping a returned fetch word while the core is stalled.
module fetch_hold_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        nrst,
    input  logic        load_i,
    input  logic        clear_i,
    input  fetch_word_t word_i,
    output fetch_word_t word_o,
    output logic        valid_o
);

    fetch_word_t word_q;
    logic        valid_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            word_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            word_q  <= word_i;
            valid_q <= 1'b1;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign word_o  = word_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, issues single-outstanding bus reads,
// handles execute redirects and holds a returned word across core stalls.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [CPU_ADDR_WIDTH-1:0]  RESET_ADDR = RESET_VECTOR_DEFAULT,
    parameter logic [CPU_INSTR_WIDTH-1:0] NOP_WORD   = NOP_WORD_DEFAULT
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       i_exec_stall,
    input  logic                       i_mem_stall,
    input  logic                       i_jump_valid,
    input  logic [CPU_ADDR_WIDTH-1:0]  i_jump_addr,
    output logic [CPU_ADDR_WIDTH-1:0]  o_IAddr,
    output logic                       o_IRdC,
    input  logic [CPU_INSTR_WIDTH-1:0] i_IData,
    input  logic                       i_IRdy,
    input  logic                       i_IErr,
    output logic [CPU_ADDR_WIDTH-1:0]  o_pc,
    output logic [CPU_INSTR_WIDTH-1:0] o_instr,
    output logic                       o_fetch_stall,
    output logic                       o_fetch_err
);

    fetch_state_e              state_q, state_d;
    logic [CPU_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [CPU_ADDR_WIDTH-1:0] iaddr_q, iaddr_d;
    logic                      irdc_q, irdc_d;
    logic                      pend_jmp_q, pend_jmp_d;
    logic [CPU_ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;

    logic                      core_stall;
    logic [CPU_ADDR_WIDTH-1:0] jump_addr;
    logic                      buf_load, buf_clear, buf_valid;
    fetch_word_t               buf_in, buf_out;

    assign core_stall = i_exec_stall | i_mem_stall;
    assign jump_addr  = word_align(i_jump_addr);

    always_comb begin
        buf_in.pc    = iaddr_q;
        buf_in.instr = i_IErr ? NOP_WORD : i_IData;
        buf_in.err   = i_IErr;
    end

    fetch_hold_buf u_hold_buf (
        .clk     (clk),
        .nrst    (nrst),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .word_i  (buf_in),
        .word_o  (buf_out),
        .valid_o (buf_valid)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= StBoot;
            pc_q        <= RESET_ADDR;
            iaddr_q     <= RESET_ADDR;
            irdc_q      <= 1'b0;
            pend_jmp_q  <= 1'b0;
            pend_addr_q <= RESET_ADDR;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            iaddr_q     <= iaddr_d;
            irdc_q      <= irdc_d;
            pend_jmp_q  <= pend_jmp_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        iaddr_d       = iaddr_q;
        irdc_d        = irdc_q;
        pend_jmp_d    = pend_jmp_q;
        pend_addr_d   = pend_addr_q;
        buf_load      = 1'b0;
        buf_clear     = 1'b0;
        o_pc          = iaddr_q;
        o_instr       = NOP_WORD;
        o_fetch_stall = 1'b1;
        o_fetch_err   = 1'b0;

        unique case (state_q)
            StBoot: begin
                state_d = StReq;
                irdc_d  = 1'b1;
                iaddr_d = i_jump_valid ? jump_addr : pc_q;
                if (i_jump_valid) begin
                    pc_d = jump_addr;
                end
            end

            StReq: begin
                if (!irdc_q) begin
                    // Idle cycle between requests: issue the next read.
                    irdc_d  = 1'b1;
                    iaddr_d = i_jump_valid ? jump_addr : pc_q;
                    if (i_jump_valid) begin
                        pc_d = jump_addr;
                    end
                end else if (i_IRdy) begin
                    irdc_d = 1'b0;
                    if (pend_jmp_q) begin
                        // Word belongs to the abandoned path; drop it silently.
                        pend_jmp_d = 1'b0;
                        pc_d       = i_jump_valid ? jump_addr : pend_addr_q;
                    end else begin
                        o_instr       = i_IErr ? NOP_WORD : i_IData;
                        o_pc          = iaddr_q;
                        o_fetch_stall = 1'b0;
                        o_fetch_err   = i_IErr;
                        if (i_jump_valid) begin
                            pc_d = jump_addr;
                        end else if (core_stall) begin
                            buf_load = 1'b1;
                            state_d  = StHold;
                        end else begin
                            pc_d = pc_q + PC_STEP;
                        end
                    end
                end else if (i_jump_valid) begin
                    pend_jmp_d  = 1'b1;
                    pend_addr_d = jump_addr;
                end
            end

            StHold: begin
                o_instr       = buf_out.instr;
                o_pc          = buf_out.pc;
                o_fetch_stall = ~buf_valid;
                // Report the error only in the cycle decode actually takes the word.
                o_fetch_err   = buf_out.err & ~core_stall;
                if (i_jump_valid) begin
                    buf_clear = 1'b1;
                    pc_d      = jump_addr;
                    iaddr_d   = jump_addr;
                    irdc_d    = 1'b1;
                    state_d   = StReq;
                end else if (!core_stall) begin
                    buf_clear = 1'b1;
                    pc_d      = pc_q + PC_STEP;
                    iaddr_d   = pc_q + PC_STEP;
                    irdc_d    = 1'b1;
                    state_d   = StReq;
                end
            end

            default: begin
                state_d = StBoot;
            end
        endcase

        // Redirect squashes whatever is presented this cycle.
        if (i_jump_valid) begin
            o_instr     = NOP_WORD;
            o_fetch_err = 1'b0;
        end
    end

    assign o_IAddr = iaddr_q;
    assign o_IRdC  = irdc_q;

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed cycle table, async reset check, then randomized
// traffic checked against an instruction-stream reference model.
module tb_fetch;

    localparam logic [31:0] B  = 32'hBFC0_0000;
    localparam logic [31:0] J  = 32'h8000_0100;
    localparam logic [31:0] W1 = 32'h2408_0001;
    localparam logic [31:0] JK = 32'hDEAD_BEEF;

    logic        clk, nrst;
    logic        i_exec_stall, i_mem_stall, i_jump_valid;
    logic [31:0] i_jump_addr, o_IAddr, i_IData, o_pc, o_instr;
    logic        o_IRdC, i_IRdy, i_IErr, o_fetch_stall, o_fetch_err;

    int nchk = 0;
    int nbad = 0;

    fetch #(
        .RESET_ADDR (32'hBFC0_0000),
        .NOP_WORD   (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .i_exec_stall  (i_exec_stall),
        .i_mem_stall   (i_mem_stall),
        .i_jump_valid  (i_jump_valid),
        .i_jump_addr   (i_jump_addr),
        .o_IAddr       (o_IAddr),
        .o_IRdC        (o_IRdC),
        .i_IData       (i_IData),
        .i_IRdy        (i_IRdy),
        .i_IErr        (i_IErr),
        .o_pc          (o_pc),
        .o_instr       (o_instr),
        .o_fetch_stall (o_fetch_stall),
        .o_fetch_err   (o_fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        es, ms, jv;
        logic [31:0] ja;
        logic        rdy, err;
        logic [31:0] data;
        logic        e_rdc;
        logic [31:0] e_addr;
        logic        e_stall;
        logic [31:0] e_pc, e_instr;
        logic        e_err;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic es, input logic ms, input logic jv, input logic [31:0] ja,
                       input logic rdy, input logic err, input logic [31:0] data,
                       input logic e_rdc, input logic [31:0] e_addr, input logic e_stall,
                       input logic [31:0] e_pc, input logic [31:0] e_instr, input logic e_err);
        vec_t v;
        v.es = es; v.ms = ms; v.jv = jv; v.ja = ja; v.rdy = rdy; v.err = err; v.data = data;
        v.e_rdc = e_rdc; v.e_addr = e_addr; v.e_stall = e_stall;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_err = e_err;
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h want %h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3C1D_5A00;
    endfunction

    task automatic drive_idle();
        i_exec_stall = 1'b0; i_mem_stall = 1'b0; i_jump_valid = 1'b0; i_jump_addr = '0;
        i_IRdy = 1'b0; i_IErr = 1'b0; i_IData = '0;
    endtask

    // Random-phase state
    logic [31:0] exp_pc, prev_addr;
    logic        last_err, prev_hold, busy;
    int          wait_left, idle_cnt, ndeliv;

    initial begin
        nrst = 1'b0;
        drive_idle();

        //        es ms jv ja        rdy er data      | rdc addr     stl pc       instr    err
        add(0, 0, 0, 0,            0, 0, 0,            0, B,        1, B,        0,       0);
        add(0, 0, 0, 0,            1, 0, W1,           1, B,        0, B,        W1,      0);
        add(0, 0, 0, 0,            0, 0, 0,            0, B,        1, B,        0,       0);
        add(0, 0, 0, 0,            0, 0, 0,            1, B+4,      1, B+4,      0,       0);
        add(0, 0, 0, 0,            0, 0, 0,            1, B+4,      1, B+4,      0,       0);
        add(0, 0, 0, 0,            0, 0, 0,            1, B+4,      1, B+4,      0,       0);
        add(0, 0, 0, 0,            1, 0, 32'h1111_0004, 1, B+4,     0, B+4, 32'h1111_0004, 0);
        add(0, 0, 0, 0,            0, 0, 0,            0, B+4,      1, B+4,      0,       0);
        add(1, 0, 0, 0,            1, 0, 32'h1111_0008, 1, B+8,     0, B+8, 32'h1111_0008, 0);
        add(1, 0, 0, 0,            1, 0, JK,           0, B+8,      0, B+8, 32'h1111_0008, 0);
        add(0, 1, 0, 0,            0, 0, 0,            0, B+8,      0, B+8, 32'h1111_0008, 0);
        add(1, 0, 0, 0,            0, 0, 0,            0, B+8,      0, B+8, 32'h1111_0008, 0);
        add(0, 0, 0, 0,            0, 0, 0,            0, B+8,      0, B+8, 32'h1111_0008, 0);
        add(0, 0, 0, 0,            1, 0, 32'h1111_000C, 1, B+12,    0, B+12, 32'h1111_000C, 0);
        add(0, 0, 0, 0,            1, 0, JK,           0, B+12,     1, B+12,     0,       0);
        add(0, 0, 1, J,            0, 0, 0,            1, B+16,     1, B+16,     0,       0);
        add(0, 0, 0, 0,            1, 0, 32'h1111_0010, 1, B+16,    1, B+16,     0,       0);
        add(0, 0, 0, 0,            0, 0, 0,            0, B+16,     1, B+16,     0,       0);
        add(0, 0, 0, 0,            1, 0, 32'h2222_0100, 1, J,       0, J,   32'h2222_0100, 0);
        add(0, 0, 0, 0,            0, 0, 0,            0, J,        1, J,        0,       0);
        add(0, 0, 1, 32'hBFC0_0017, 1, 0, 32'h2222_0104, 1, J+4,    0, J+4,      0,       0);
        add(0, 0, 0, 0,            0, 0, 0,            0, J+4,      1, J+4,      0,       0);
        add(0, 0, 0, 0,            1, 1, JK,           1, B+20,     0, B+20,     0,       1);
        add(0, 0, 0, 0,            0, 0, 0,            0, B+20,     1, B+20,     0,       0);
        add(0, 0, 0, 0,            0, 0, 0,            1, B+24,     1, B+24,     0,       0);

        // Reset values while still held in reset
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rdc", 32'(o_IRdC), 32'd0);
        chk("rst_addr", o_IAddr, B);
        chk("rst_stall", 32'(o_fetch_stall), 32'd1);
        chk("rst_pc", o_pc, B);
        chk("rst_instr", o_instr, 32'd0);
        chk("rst_err", 32'(o_fetch_err), 32'd0);

        @(negedge clk);
        nrst = 1'b1;
        for (int i = 0; i < vt.size(); i++) begin
            i_exec_stall = vt[i].es; i_mem_stall = vt[i].ms;
            i_jump_valid = vt[i].jv; i_jump_addr = vt[i].ja;
            i_IRdy = vt[i].rdy; i_IErr = vt[i].err; i_IData = vt[i].data;
            #1;
            chk($sformatf("c%0d_rdc", i), 32'(o_IRdC), 32'(vt[i].e_rdc));
            chk($sformatf("c%0d_addr", i), o_IAddr, vt[i].e_addr);
            chk($sformatf("c%0d_stall", i), 32'(o_fetch_stall), 32'(vt[i].e_stall));
            chk($sformatf("c%0d_pc", i), o_pc, vt[i].e_pc);
            chk($sformatf("c%0d_instr", i), o_instr, vt[i].e_instr);
            chk($sformatf("c%0d_err", i), 32'(o_fetch_err), 32'(vt[i].e_err));
            @(negedge clk);
        end

        // Async reset in the middle of an outstanding request
        drive_idle();
        #1;
        chk("mid_rdc_before", 32'(o_IRdC), 32'd1);
        #1;
        nrst = 1'b0;
        #1;
        chk("arst_rdc", 32'(o_IRdC), 32'd0);
        chk("arst_addr", o_IAddr, B);
        chk("arst_stall", 32'(o_fetch_stall), 32'd1);
        chk("arst_pc", o_pc, B);
        chk("arst_instr", o_instr, 32'd0);
        chk("arst_err", 32'(o_fetch_err), 32'd0);

        // Randomized traffic against the instruction-stream model
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        exp_pc = B; last_err = 1'b0; prev_hold = 1'b0; prev_addr = '0;
        busy = 1'b0; wait_left = 0; idle_cnt = 0; ndeliv = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            i_exec_stall = ($urandom_range(0, 5) == 0);
            i_mem_stall  = ($urandom_range(0, 7) == 0);
            i_jump_valid = ($urandom_range(0, 24) == 0);
            i_jump_addr  = ($urandom_range(0, 3) == 0) ?
                           (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            if (o_IRdC) begin
                if (!busy) begin
                    busy = 1'b1;
                    wait_left = $urandom_range(0, 3);
                end
                if (wait_left == 0) begin
                    i_IRdy = 1'b1;
                    i_IErr = ($urandom_range(0, 11) == 0);
                    i_IData = mem(o_IAddr);
                    busy = 1'b0;
                end else begin
                    i_IRdy = 1'b0; i_IErr = 1'b0; i_IData = $urandom;
                    wait_left--;
                end
            end else begin
                i_IRdy = ($urandom_range(0, 9) == 0);
                i_IErr = ($urandom_range(0, 1) == 0);
                i_IData = $urandom;
            end
            #1;
            if (prev_hold) begin
                chk("bus_hold_rdc", 32'(o_IRdC), 32'd1);
                chk("bus_hold_addr", o_IAddr, prev_addr);
            end
            if (o_IRdC && i_IRdy) last_err = i_IErr;
            if (i_jump_valid) begin
                chk("squash_instr", o_instr, 32'd0);
                chk("squash_err", 32'(o_fetch_err), 32'd0);
                exp_pc = {i_jump_addr[31:2], 2'b00};
            end else if (!o_fetch_stall && !i_exec_stall && !i_mem_stall) begin
                chk("rnd_pc", o_pc, exp_pc);
                chk("rnd_instr", o_instr, last_err ? 32'd0 : mem(exp_pc));
                chk("rnd_err", 32'(o_fetch_err), 32'(last_err));
                exp_pc = exp_pc + 32'd4;
                idle_cnt = 0;
                ndeliv++;
            end else begin
                idle_cnt++;
                if (idle_cnt > 150) begin
                    nchk++;
                    nbad++;
                    $display("FAIL liveness: got %0d idle cycles want <= 150", idle_cnt);
                    idle_cnt = 0;
                end
            end
            prev_hold = o_IRdC && !i_IRdy;
            prev_addr = o_IAddr;
            @(negedge clk);
        end
        chk("rnd_some_delivered", 32'(ndeliv > 500), 32'd1);

        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule
